device_spi_master: RTL and testbench
====================================

DEVICE_SPI_MASTER -- requirements
Module: device_spi_master

Interface
REQ-001 SHALL have parameter SPI_BITS, default 3, number of parallel SPI data lanes.
REQ-002 SHALL have parameter MODULE_ID_BITS, default 3, width of the module select bus.
REQ-003 SHALL have parameter CLK_DIV, default 4, sclk half-period in clk cycles (legal range 1..255).
REQ-004 SHALL have parameter WORD_CYCLES, default 8, sclk cycles per word (word width = SPI_BITS*WORD_CYCLES).
REQ-005 Ports: clk  in  1  single clock; all logic on rising edge.
REQ-006 Ports: nreset  in  1  asynchronous active-low reset.
REQ-007 Ports: cmd_valid in 1, cmd_ready out 1, cmd_id in MODULE_ID_BITS  start-of-transaction handshake and target id.
REQ-008 Ports: tx_valid in 1, tx_ready out 1, tx_data in SPI_BITS*WORD_CYCLES, tx_last in 1  outgoing word stream.
REQ-009 Ports: rx_valid out 1, rx_data out SPI_BITS*WORD_CYCLES  received word, one-cycle pulse, no backpressure.
REQ-010 Ports: busy out 1; module_id out MODULE_ID_BITS; sclk out 1; sdi out SPI_BITS (to slave); sdo in SPI_BITS (from slave).

Function
REQ-011 SHALL be the initiator end of the device-handler SPI link: drives sclk, sdi lanes and module_id; samples sdo lanes.
REQ-012 module_id SHALL be all-ones (deselect) whenever no transaction is active; cmd_id all-ones is legal and addresses nothing.
REQ-013 SPI mode 0: sclk idles low; sdi changes only while sclk low; sdo sampled on sclk rising edge.
REQ-014 Lane mapping: lane l carries tx_data[l*WORD_CYCLES +: WORD_CYCLES], MSB first; rx_data uses identical mapping.
REQ-015 FSM states IDLE, SETUP, LOAD, SHIFT, HOLD.
REQ-016 IDLE: cmd_ready=1; on cmd_valid&&cmd_ready latch cmd_id onto module_id, go SETUP.
REQ-017 SETUP: wait CLK_DIV cycles with sclk low, go LOAD.
REQ-018 LOAD: tx_ready=1; on tx_valid latch tx_data and tx_last, drive first bit of each lane onto sdi, go SHIFT; without tx_valid stay in LOAD, sclk held low, module_id held (stall legal).
REQ-019 SHIFT: sclk toggles every CLK_DIV cycles; on each rising edge shift sdo into rx shift register; on each falling edge present next bit; WORD_CYCLES full sclk periods per word.
REQ-020 After the last falling edge of a word: rx_valid pulses one cycle with rx_data; then LOAD if latched tx_last=0, else HOLD.
REQ-021 HOLD: keep module_id for CLK_DIV cycles with sclk low, then module_id all-ones, go IDLE.
REQ-022 cmd_ready=0 and busy=1 in all states except IDLE.
REQ-023 tx_ready SHALL be high only in LOAD; tx_valid outside LOAD is ignored.
REQ-024 Divider counter 8 bits, reloads on every sclk edge; word bit counter wraps at WORD_CYCLES.
REQ-025 First rx_valid SHALL occur exactly 2*CLK_DIV*WORD_CYCLES cycles after the LOAD handshake cycle.

Reset
REQ-026 nreset low SHALL asynchronously force IDLE, sclk=0, sdi=0, module_id=all-ones, rx_valid=0, rx_data=0, busy=0, tx_ready=0; cmd_ready=1 after release.
REQ-027 Reset mid-transaction SHALL abort without emitting rx_valid; partial word discarded.

Structure
REQ-028 State encoding and the deselect-id constant SHALL live in a shared package device_pkg.
REQ-029 The sclk divider/edge generator SHALL be one sub-module spi_clk_gen (outputs rise/fall strobes).
REQ-030 No other sub-modules; rx and tx shift registers local to the top.

Verification
REQ-031 cmd_id=2, one word 0xA5_3C_F0 tx_last=1, slave loopback sdo=sdi -> rx_data=0xA5_3C_F0, module_id=2 for whole frame, then 7.
REQ-032 Three-word burst with tx_valid withheld 20 cycles before word 2 -> sclk low and module_id steady during stall, three rx_valid pulses.
REQ-033 CLK_DIV=1 -> sclk period 2 clk, first rx_valid 16 cycles after LOAD handshake.
REQ-034 nreset asserted mid-word 1 -> sclk=0, module_id=7 immediately, no rx_valid, next transaction succeeds.
REQ-035 cmd_valid while busy -> cmd_ready=0, command not accepted until IDLE.

Source files
------------

// File: rtl/device_pkg.sv
// Shared definitions for the device-handler SPI master: FSM encoding,
// divider width and the module-select value meaning "nobody addressed".
package device_pkg;

  // Transaction phases of the SPI master.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_HOLD  = 3'd4
  } spi_state_e;

  // Width of the sclk half-period divider (CLK_DIV up to 255).
  localparam int DIV_CNT_BITS = 8;

  // Deselect id: all ones. Consumers slice the low MODULE_ID_BITS bits.
  localparam logic [31:0] DESELECT_ID = 32'hFFFF_FFFF;

  // Reload value of a down-counter that must expire after 'div' cycles.
  function automatic logic [DIV_CNT_BITS-1:0] div_reload(input int div);
    return DIV_CNT_BITS'(div - 1);
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// sclk divider / edge generator. While enabled, sclk toggles every CLK_DIV
// clk cycles starting from low. rise/fall are single-cycle strobes asserted
// in the clk cycle whose closing edge makes sclk go high/low, so the
// consumer can sample or shift on that same clk edge.
module spi_clk_gen
  import device_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic nreset,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam logic [DIV_CNT_BITS-1:0] RELOAD  = div_reload(CLK_DIV);
  localparam logic [DIV_CNT_BITS-1:0] CNT_ONE = DIV_CNT_BITS'(1);

  logic [DIV_CNT_BITS-1:0] cnt_q, cnt_d;
  logic                    sclk_q, sclk_d;
  logic                    tick;

  // Divider: reload while disabled and on every sclk edge, else count down.
  always_comb begin
    tick   = en && (cnt_q == '0);
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en) begin
      cnt_d  = RELOAD;
      sclk_d = 1'b0;
    end else if (tick) begin
      cnt_d  = RELOAD;
      sclk_d = ~sclk_q;
    end else begin
      cnt_d  = cnt_q - CNT_ONE;
    end
  end

  assign rise = tick && !sclk_q;
  assign fall = tick && sclk_q;
  assign sclk = sclk_q;

  // Divider and sclk state registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q  <= RELOAD;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/device_spi_master.sv
// Initiator end of the device-handler SPI link (mode 0, SPI_BITS parallel
// lanes, MSB first per lane). A command selects a target via module_id, then
// words are streamed through tx and returned on rx until a word tagged
// tx_last completes.
//
// Handshakes: cmd and tx are valid/ready; a transfer happens on the rising
// clk edge where valid and ready are both high, valid must not depend on
// ready, and payload is only looked at in that cycle. rx is a push-only
// stream: rx_valid is a one-cycle pulse with no backpressure.
//
// Timing: sclk stays low for CLK_DIV cycles after the tx transfer edge, so
// the first bit is set up half a period ahead of the first rising edge.
// rx_valid rises on the clk edge 2*CLK_DIV*WORD_CYCLES edges after the tx
// transfer edge, together with the final sclk falling edge.
module device_spi_master
  import device_pkg::*;
#(
  parameter int SPI_BITS       = 3,
  parameter int MODULE_ID_BITS = 3,
  parameter int CLK_DIV        = 4,
  parameter int WORD_CYCLES    = 8
) (
  input  logic                              clk,
  input  logic                              nreset,
  // command: start of transaction and target id
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [MODULE_ID_BITS-1:0]         cmd_id,
  // outgoing word stream
  input  logic                              tx_valid,
  output logic                              tx_ready,
  input  logic [SPI_BITS*WORD_CYCLES-1:0]   tx_data,
  input  logic                              tx_last,
  // received words
  output logic                              rx_valid,
  output logic [SPI_BITS*WORD_CYCLES-1:0]   rx_data,
  // status and SPI pins
  output logic                              busy,
  output logic [MODULE_ID_BITS-1:0]         module_id,
  output logic                              sclk,
  output logic [SPI_BITS-1:0]               sdi,
  input  logic [SPI_BITS-1:0]               sdo,
  // FSM state for observation
  output spi_state_e                        dbg_state
);

  localparam int WORD_W    = SPI_BITS * WORD_CYCLES;
  localparam int BIT_CNT_W = (WORD_CYCLES > 1) ? $clog2(WORD_CYCLES) : 1;

  localparam logic [BIT_CNT_W-1:0]      LAST_BIT = BIT_CNT_W'(WORD_CYCLES - 1);
  localparam logic [BIT_CNT_W-1:0]      BIT_ONE  = BIT_CNT_W'(1);
  localparam logic [DIV_CNT_BITS-1:0]   WAIT_LD  = div_reload(CLK_DIV);
  localparam logic [DIV_CNT_BITS-1:0]   WAIT_ONE = DIV_CNT_BITS'(1);
  localparam logic [MODULE_ID_BITS-1:0] ID_DESEL = DESELECT_ID[MODULE_ID_BITS-1:0];

  spi_state_e                state_q, state_d;
  logic [DIV_CNT_BITS-1:0]   wait_q, wait_d;
  logic [BIT_CNT_W-1:0]      bit_q, bit_d;
  logic [WORD_W-1:0]         tx_sh_q, tx_sh_d;
  logic [WORD_W-1:0]         rx_sh_q, rx_sh_d;
  logic [WORD_W-1:0]         rx_data_q, rx_data_d;
  logic                      rx_valid_q, rx_valid_d;
  logic                      last_q, last_d;
  logic [MODULE_ID_BITS-1:0] module_id_q, module_id_d;

  logic shift_en;
  logic sclk_rise;
  logic sclk_fall;

  // sclk runs only while a word is being shifted.
  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk    (clk),
    .nreset (nreset),
    .en     (shift_en),
    .sclk   (sclk),
    .rise   (sclk_rise),
    .fall   (sclk_fall)
  );

  // Next-state logic: phase sequencing, shift registers and handshakes.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    bit_d       = bit_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    last_d      = last_q;
    module_id_d = module_id_q;
    shift_en    = 1'b0;
    tx_ready    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          module_id_d = cmd_id;
          wait_d      = WAIT_LD;
          state_d     = ST_SETUP;
        end
      end

      // Target selected, sclk low: give the slave CLK_DIV cycles of setup.
      ST_SETUP: begin
        if (wait_q == '0) begin
          state_d = ST_LOAD;
        end else begin
          wait_d = wait_q - WAIT_ONE;
        end
      end

      // Waiting for a word; stalling here keeps sclk low and the id held.
      ST_LOAD: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          tx_sh_d = tx_data;
          last_d  = tx_last;
          bit_d   = '0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        shift_en = 1'b1;
        if (sclk_rise) begin
          for (int l = 0; l < SPI_BITS; l++) begin
            rx_sh_d[l*WORD_CYCLES +: WORD_CYCLES] = rx_sh_q[l*WORD_CYCLES +: WORD_CYCLES] << 1;
            rx_sh_d[l*WORD_CYCLES] = sdo[l];
          end
        end
        if (sclk_fall) begin
          for (int l = 0; l < SPI_BITS; l++) begin
            tx_sh_d[l*WORD_CYCLES +: WORD_CYCLES] = tx_sh_q[l*WORD_CYCLES +: WORD_CYCLES] << 1;
          end
          if (bit_q == LAST_BIT) begin
            bit_d      = '0;
            rx_valid_d = 1'b1;
            rx_data_d  = rx_sh_q;
            wait_d     = WAIT_LD;
            state_d    = last_q ? ST_HOLD : ST_LOAD;
          end else begin
            bit_d = bit_q + BIT_ONE;
          end
        end
      end

      // Keep the target selected for CLK_DIV cycles after the last edge.
      ST_HOLD: begin
        if (wait_q == '0) begin
          module_id_d = ID_DESEL;
          state_d     = ST_IDLE;
        end else begin
          wait_d = wait_q - WAIT_ONE;
        end
      end

      default: begin
        module_id_d = ID_DESEL;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // Lane l drives the MSB of its slice of the tx shift register.
  always_comb begin
    sdi = '0;
    for (int l = 0; l < SPI_BITS; l++) begin
      sdi[l] = tx_sh_q[l*WORD_CYCLES + WORD_CYCLES - 1];
    end
  end

  assign cmd_ready = (state_q == ST_IDLE) && nreset;
  assign busy      = (state_q != ST_IDLE);
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign module_id = module_id_q;
  assign dbg_state = state_q;

  // State registers; reset aborts any transfer and discards partial words.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= ST_IDLE;
      wait_q      <= '0;
      bit_q       <= '0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      last_q      <= 1'b0;
      module_id_q <= ID_DESEL;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      bit_q       <= bit_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      last_q      <= last_d;
      module_id_q <= module_id_d;
    end
  end

endmodule

// File: tb/tb_device_spi_master.sv
// Directed bench for device_spi_master: default instance (CLK_DIV=4) with
// sdo looped back or forced, plus a CLK_DIV=1 instance for the fast divider.
module tb_device_spi_master;
  import device_pkg::*;

  localparam int WW    = 24;
  localparam int DIV   = 4;
  localparam int LAT   = 64;  // 2*4*8
  localparam logic [2:0] DESEL = 3'b111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  // ---------------- main instance ----------------
  logic          cmd_valid, cmd_ready, tx_valid, tx_ready, tx_last, rx_valid, busy, sclk;
  logic [2:0]    cmd_id, module_id, sdi, sdo, sdo_force;
  logic [WW-1:0] tx_data, rx_data;
  logic          loop_en;
  spi_state_e    dbg_state;
  assign sdo = loop_en ? sdi : sdo_force;

  device_spi_master dut (
    .clk(clk), .nreset(nreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_last(tx_last),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .busy(busy), .module_id(module_id), .sclk(sclk), .sdi(sdi), .sdo(sdo),
    .dbg_state(dbg_state)
  );

  // ---------------- fast instance (CLK_DIV=1) ----------------
  logic          f_cmd_valid, f_cmd_ready, f_tx_valid, f_tx_ready, f_tx_last, f_rx_valid, f_busy, f_sclk;
  logic [2:0]    f_cmd_id, f_module_id, f_sdi, f_sdo;
  logic [WW-1:0] f_tx_data, f_rx_data;
  spi_state_e    f_dbg_state;
  assign f_sdo = f_sdi;

  device_spi_master #(.CLK_DIV(1)) dut_fast (
    .clk(clk), .nreset(nreset),
    .cmd_valid(f_cmd_valid), .cmd_ready(f_cmd_ready), .cmd_id(f_cmd_id),
    .tx_valid(f_tx_valid), .tx_ready(f_tx_ready), .tx_data(f_tx_data), .tx_last(f_tx_last),
    .rx_valid(f_rx_valid), .rx_data(f_rx_data),
    .busy(f_busy), .module_id(f_module_id), .sclk(f_sclk), .sdi(f_sdi), .sdo(f_sdo),
    .dbg_state(f_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int            total;
  int            bad;
  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] exp_word;

  // ---------------- driver / monitor tasks ----------------
  task automatic send_cmd(input logic [2:0] id);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_id    = id;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_tx_ready(output int cyc);
    cyc = -1;
    for (int n = 0; n <= 200; n++) begin
      if (n > 0) @(negedge clk);
      if (tx_ready === 1'b1) begin
        cyc = n;
        break;
      end
    end
  endtask

  // Present one word at the current negedge; returns after the transfer edge.
  task automatic send_word(input logic [WW-1:0] data, input logic last);
    tx_valid = 1'b1;
    tx_data  = data;
    tx_last  = last;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = '0;
    tx_last  = 1'b0;
  endtask

  // Observe one word from the transfer edge to rx_valid.
  task automatic watch_word(input logic [2:0] id_exp, output int lat, output int rises,
                            output int sdi_bad, output int id_bad, output int ready_bad,
                            output logic [WW-1:0] got);
    logic       prev_sclk;
    logic [2:0] prev_sdi;
    lat = -1; rises = 0; sdi_bad = 0; id_bad = 0; ready_bad = 0; got = '0;
    prev_sclk = sclk;
    prev_sdi  = sdi;
    for (int n = 1; n <= 1000; n++) begin
      @(negedge clk);
      if (sclk === 1'b1 && prev_sclk === 1'b0) rises++;
      if (sdi !== prev_sdi && sclk !== 1'b0) sdi_bad++;
      if (module_id !== id_exp) id_bad++;
      if (cmd_ready !== 1'b0 || busy !== 1'b1) ready_bad++;
      prev_sclk = sclk;
      prev_sdi  = sdi;
      if (rx_valid === 1'b1) begin
        lat = n;
        got = rx_data;
        break;
      end
    end
  endtask

  // Count cycles from rx_valid until deselect; also counts stray rx pulses.
  task automatic wait_deselect(output int cyc, output int extra_rx);
    cyc = -1; extra_rx = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (rx_valid === 1'b1) extra_rx++;
      if (module_id === DESEL) begin
        cyc = n;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    nreset = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (sclk !== 1'b0) begin bad++; $display("FAIL rst_sclk got=%b exp=0", sclk); end
    total++; if (sdi !== 3'b000) begin bad++; $display("FAIL rst_sdi got=%b exp=000", sdi); end
    total++; if (module_id !== DESEL) begin bad++; $display("FAIL rst_module_id got=%0d exp=7", module_id); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rst_rx_valid got=%b exp=0", rx_valid); end
    total++; if (rx_data !== 24'h0) begin bad++; $display("FAIL rst_rx_data got=%h exp=000000", rx_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL rst_tx_ready got=%b exp=0", tx_ready); end
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
    total++; if (f_module_id !== DESEL || f_sclk !== 1'b0) begin bad++; $display("FAIL rst_fast got=%0d/%b exp=7/0", f_module_id, f_sclk); end
    nreset = 1'b1;
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_single_word();
    int lat, rises, sdi_bad, id_bad, ready_bad, cyc, extra;
    logic [WW-1:0] got;
    send_cmd(3'd2);
    total++; if (module_id !== 3'd2) begin bad++; $display("FAIL single_id_latch got=%0d exp=2", module_id); end
    total++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin bad++; $display("FAIL single_busy got=%b/%b exp=1/0", busy, cmd_ready); end
    wait_tx_ready(cyc);
    total++; if (cyc !== DIV) begin bad++; $display("FAIL single_setup_cycles got=%0d exp=%0d", cyc, DIV); end
    exp_q.push_back(24'hA53CF0);
    send_word(24'hA53CF0, 1'b1);
    total++; if (sdi !== 3'b101) begin bad++; $display("FAIL single_first_bits got=%b exp=101", sdi); end
    total++; if (sclk !== 1'b0) begin bad++; $display("FAIL single_sclk_low got=%b exp=0", sclk); end
    watch_word(3'd2, lat, rises, sdi_bad, id_bad, ready_bad, got);
    total++; if (lat !== LAT) begin bad++; $display("FAIL single_latency got=%0d exp=%0d", lat, LAT); end
    total++; if (rises !== 8) begin bad++; $display("FAIL single_sclk_rises got=%0d exp=8", rises); end
    total++; if (sdi_bad !== 0) begin bad++; $display("FAIL single_sdi_while_high got=%0d exp=0", sdi_bad); end
    total++; if (id_bad !== 0) begin bad++; $display("FAIL single_id_steady got=%0d exp=0", id_bad); end
    total++; if (ready_bad !== 0) begin bad++; $display("FAIL single_cmd_ready_busy got=%0d exp=0", ready_bad); end
    exp_word = exp_q.pop_front();
    total++; if (got !== exp_word) begin bad++; $display("FAIL single_rx_data got=%h exp=%h", got, exp_word); end
    wait_deselect(cyc, extra);
    total++; if (cyc !== DIV) begin bad++; $display("FAIL single_hold_cycles got=%0d exp=%0d", cyc, DIV); end
    total++; if (extra !== 0) begin bad++; $display("FAIL single_rx_pulse_width got=%0d exp=0", extra); end
    total++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL single_idle got=%b/%b exp=0/1", busy, cmd_ready); end
  endtask

  task automatic test_burst_stall();
    int lat, rises, sdi_bad, id_bad, ready_bad, cyc, extra, pulses, stall_bad;
    logic [WW-1:0] got;
    logic [WW-1:0] words [3];
    words[0] = 24'h123456; words[1] = 24'h89ABCD; words[2] = 24'h00F00F;
    pulses = 0;
    send_cmd(3'd5);
    wait_tx_ready(cyc);
    for (int w = 0; w < 3; w++) begin
      if (w == 1) begin
        stall_bad = 0;
        for (int s = 0; s < 20; s++) begin
          @(negedge clk);
          if (sclk !== 1'b0 || module_id !== 3'd5 || tx_ready !== 1'b1 || busy !== 1'b1) stall_bad++;
        end
        total++; if (stall_bad !== 0) begin bad++; $display("FAIL burst_stall_steady got=%0d exp=0", stall_bad); end
      end
      exp_q.push_back(words[w]);
      send_word(words[w], (w == 2));
      watch_word(3'd5, lat, rises, sdi_bad, id_bad, ready_bad, got);
      if (lat > 0) pulses++;
      total++; if (lat !== LAT) begin bad++; $display("FAIL burst_latency w%0d got=%0d exp=%0d", w, lat, LAT); end
      total++; if (id_bad !== 0 || sdi_bad !== 0) begin bad++; $display("FAIL burst_frame w%0d got=%0d/%0d exp=0/0", w, id_bad, sdi_bad); end
      exp_word = exp_q.pop_front();
      total++; if (got !== exp_word) begin bad++; $display("FAIL burst_rx_data w%0d got=%h exp=%h", w, got, exp_word); end
    end
    total++; if (pulses !== 3) begin bad++; $display("FAIL burst_pulses got=%0d exp=3", pulses); end
    wait_deselect(cyc, extra);
    total++; if (cyc !== DIV) begin bad++; $display("FAIL burst_hold got=%0d exp=%0d", cyc, DIV); end
  endtask

  task automatic test_lane_map();
    int lat, rises, sdi_bad, id_bad, ready_bad, cyc, extra;
    logic [WW-1:0] got;
    loop_en   = 1'b0;
    sdo_force = 3'b110;  // lane0 reads 0s, lanes 1 and 2 read 1s
    send_cmd(3'd1);
    wait_tx_ready(cyc);
    send_word(24'h000000, 1'b1);
    watch_word(3'd1, lat, rises, sdi_bad, id_bad, ready_bad, got);
    total++; if (got !== 24'hFFFF00) begin bad++; $display("FAIL lane_map_rx got=%h exp=ffff00", got); end
    wait_deselect(cyc, extra);
    loop_en = 1'b1;
  endtask

  task automatic test_fast_div();
    int cyc, lat, highs;
    logic [WW-1:0] got;
    @(negedge clk);
    total++; if (f_cmd_ready !== 1'b1) begin bad++; $display("FAIL fast_cmd_ready got=%b exp=1", f_cmd_ready); end
    f_cmd_valid = 1'b1;
    f_cmd_id    = 3'd3;
    @(negedge clk);
    f_cmd_valid = 1'b0;
    cyc = -1;
    for (int n = 0; n <= 50; n++) begin
      if (n > 0) @(negedge clk);
      if (f_tx_ready === 1'b1) begin cyc = n; break; end
    end
    total++; if (cyc !== 1) begin bad++; $display("FAIL fast_setup got=%0d exp=1", cyc); end
    f_tx_valid = 1'b1;
    f_tx_data  = 24'h5AC381;
    f_tx_last  = 1'b1;
    @(negedge clk);
    f_tx_valid = 1'b0;
    lat = -1; highs = 0; got = '0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (f_sclk === 1'b1) highs++;
      if (f_rx_valid === 1'b1) begin lat = n; got = f_rx_data; break; end
    end
    total++; if (lat !== 16) begin bad++; $display("FAIL fast_latency got=%0d exp=16", lat); end
    total++; if (highs !== 8) begin bad++; $display("FAIL fast_sclk_high_cycles got=%0d exp=8", highs); end
    total++; if (got !== 24'h5AC381) begin bad++; $display("FAIL fast_rx_data got=%h exp=5ac381", got); end
    cyc = -1;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      if (f_module_id === DESEL) begin cyc = n; break; end
    end
    total++; if (cyc !== 1) begin bad++; $display("FAIL fast_hold got=%0d exp=1", cyc); end
  endtask

  task automatic test_reset_abort();
    int lat, rises, sdi_bad, id_bad, ready_bad, cyc, extra, rx_seen, busy_seen;
    logic [WW-1:0] got;
    send_cmd(3'd3);
    wait_tx_ready(cyc);
    send_word(24'h0F0F0F, 1'b1);
    repeat (20) @(negedge clk);
    for (int n = 0; n < 20; n++) begin
      if (sclk === 1'b1) break;
      @(negedge clk);
    end
    total++; if (sclk !== 1'b1) begin bad++; $display("FAIL abort_sclk_high_before got=%b exp=1", sclk); end
    #2;
    nreset = 1'b0;
    #1;
    total++; if (sclk !== 1'b0) begin bad++; $display("FAIL abort_sclk got=%b exp=0", sclk); end
    total++; if (module_id !== DESEL) begin bad++; $display("FAIL abort_module_id got=%0d exp=7", module_id); end
    total++; if (busy !== 1'b0 || rx_valid !== 1'b0) begin bad++; $display("FAIL abort_busy_rx got=%b/%b exp=0/0", busy, rx_valid); end
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    rx_seen = 0; busy_seen = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (rx_valid !== 1'b0) rx_seen++;
      if (busy !== 1'b0) busy_seen++;
    end
    total++; if (rx_seen !== 0 || busy_seen !== 0) begin bad++; $display("FAIL abort_quiet got=%0d/%0d exp=0/0", rx_seen, busy_seen); end
    send_cmd(3'd6);
    wait_tx_ready(cyc);
    exp_q.push_back(24'h0F1E2D);
    send_word(24'h0F1E2D, 1'b1);
    watch_word(3'd6, lat, rises, sdi_bad, id_bad, ready_bad, got);
    total++; if (lat !== LAT) begin bad++; $display("FAIL abort_next_latency got=%0d exp=%0d", lat, LAT); end
    exp_word = exp_q.pop_front();
    total++; if (got !== exp_word) begin bad++; $display("FAIL abort_next_rx got=%h exp=%h", got, exp_word); end
    wait_deselect(cyc, extra);
  endtask

  task automatic test_cmd_while_busy();
    int lat, rises, sdi_bad, id_bad, ready_bad, cyc, extra, desel_cycles;
    logic [WW-1:0] got;
    send_cmd(3'd4);
    cmd_valid = 1'b1;
    cmd_id    = 3'd6;
    wait_tx_ready(cyc);
    total++; if (cmd_ready !== 1'b0 || module_id !== 3'd4) begin bad++; $display("FAIL busy_cmd_blocked got=%b/%0d exp=0/4", cmd_ready, module_id); end
    exp_q.push_back(24'h3C3C3C);
    send_word(24'h3C3C3C, 1'b1);
    watch_word(3'd4, lat, rises, sdi_bad, id_bad, ready_bad, got);
    total++; if (id_bad !== 0 || ready_bad !== 0) begin bad++; $display("FAIL busy_frame got=%0d/%0d exp=0/0", id_bad, ready_bad); end
    exp_word = exp_q.pop_front();
    total++; if (got !== exp_word) begin bad++; $display("FAIL busy_rx got=%h exp=%h", got, exp_word); end
    cyc = -1; desel_cycles = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (module_id === DESEL) desel_cycles++;
      if (module_id === 3'd6) begin cyc = n; break; end
    end
    cmd_valid = 1'b0;
    total++; if (cyc !== DIV + 1) begin bad++; $display("FAIL busy_accept_after_idle got=%0d exp=%0d", cyc, DIV + 1); end
    total++; if (desel_cycles !== 1) begin bad++; $display("FAIL busy_deselect_gap got=%0d exp=1", desel_cycles); end
    wait_tx_ready(cyc);
    exp_q.push_back(24'hC3C3C3);
    send_word(24'hC3C3C3, 1'b1);
    watch_word(3'd6, lat, rises, sdi_bad, id_bad, ready_bad, got);
    exp_word = exp_q.pop_front();
    total++; if (got !== exp_word) begin bad++; $display("FAIL busy_second_rx got=%h exp=%h", got, exp_word); end
    wait_deselect(cyc, extra);
    total++; if (cyc !== DIV) begin bad++; $display("FAIL busy_second_hold got=%0d exp=%0d", cyc, DIV); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total = 0; bad = 0;
    nreset = 1'b0;
    cmd_valid = 1'b0; cmd_id = '0; tx_valid = 1'b0; tx_data = '0; tx_last = 1'b0;
    loop_en = 1'b1; sdo_force = '0;
    f_cmd_valid = 1'b0; f_cmd_id = '0; f_tx_valid = 1'b0; f_tx_data = '0; f_tx_last = 1'b0;
    test_reset();
    test_single_word();
    test_burst_stall();
    test_lane_map();
    test_fast_div();
    test_reset_abort();
    test_cmd_while_busy();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Run-time bound in case a task loop never completes.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
